// File: rtl/hdmi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_rx_pkg
//  Purpose  : Shared definitions for the HDMI RX clock/reset blocks: sequencer
//             state encoding, state width and default timing constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hdmi_rx_pkg;

  localparam int unsigned c_STATE_W = 3;
  localparam int unsigned c_RETRY_W = 8;

  // Encoding is visible on o_state, so the values are fixed.
  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_MMCM_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_t;

  localparam int unsigned c_DEF_RST_CYCLES    = 16;
  localparam int unsigned c_DEF_LOCK_TIMEOUT  = 100000;
  localparam int unsigned c_DEF_SETTLE_CYCLES = 64;
  localparam int unsigned c_DEF_ACT_WINDOW    = 1024;
  localparam int unsigned c_DEF_MIN_EDGES     = 4;

endpackage
`default_nettype wire

// File: rtl/hdmi_rx_clk_rst_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_rx_clk_rst_seq_if
//  Purpose  : Signal bundle between the RX clock/reset sequencer and its
//             environment (MMCM, deserializers, debug).
//  Signals  : i_pixclk_toggle, i_mmcm_locked  -> into sequencer (async)
//             o_mmcm_rst, o_serdes_rst, o_ready, o_state, o_retry_cnt,
//             o_timeout                      <- from sequencer
//  Modports : slave  = sequencer side, master = environment side
//  Revision : 1.0  initial release
// ============================================================================
interface hdmi_rx_clk_rst_seq_if;
  import hdmi_rx_pkg::*;

  logic                 i_pixclk_toggle;
  logic                 i_mmcm_locked;
  logic                 o_mmcm_rst;
  logic                 o_serdes_rst;
  logic                 o_ready;
  logic [c_STATE_W-1:0] o_state;
  logic [c_RETRY_W-1:0] o_retry_cnt;
  logic                 o_timeout;

  modport slave (
    input  i_pixclk_toggle, i_mmcm_locked,
    output o_mmcm_rst, o_serdes_rst, o_ready, o_state, o_retry_cnt, o_timeout
  );

  modport master (
    output i_pixclk_toggle, i_mmcm_locked,
    input  o_mmcm_rst, o_serdes_rst, o_ready, o_state, o_retry_cnt, o_timeout
  );

endinterface
`default_nettype wire

// File: rtl/hdmi_rx_clk_activity.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_rx_clk_activity
//  Purpose  : Pixel-clock presence detector. Synchronizes a toggle generated
//             in the pixel domain, counts its edges over a fixed window of
//             system clocks and flags the clock present when enough edges
//             were seen in the last complete window.
//  Ports    : i_clk          system clock
//             i_rst_n        synchronous active-low reset
//             i_toggle       async toggle from the pixel domain
//             o_clk_present  registered presence flag (updates at window wrap)
//  Revision : 1.0  initial release
// ============================================================================
module hdmi_rx_clk_activity
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned ACT_WINDOW = c_DEF_ACT_WINDOW,
  parameter int unsigned MIN_EDGES  = c_DEF_MIN_EDGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_toggle,
  output logic o_clk_present
);

  localparam int unsigned c_WIN_W  = $clog2(ACT_WINDOW + 1);
  localparam int unsigned c_EDGE_W = $clog2(MIN_EDGES + 1);
  localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(ACT_WINDOW - 1);
  localparam logic [c_EDGE_W-1:0] c_EDGE_MAX = c_EDGE_W'(MIN_EDGES);

  logic                r_tog_s1;
  logic                r_tog_s2;
  logic                r_tog_s3;
  logic [c_WIN_W-1:0]  r_win;
  logic [c_EDGE_W-1:0] r_edges;
  logic                r_present;
  logic                w_edge;
  logic [c_EDGE_W-1:0] w_edges_inc;

  // s1/s2 form the synchronizer; s3 only delays s2 for edge detection.
  assign w_edge = r_tog_s2 ^ r_tog_s3;

  // Saturating count that includes an edge arriving in the current cycle,
  // so the wrap decision covers the whole window.
  assign w_edges_inc = (w_edge && (r_edges != c_EDGE_MAX)) ?
                       r_edges + c_EDGE_W'(1) : r_edges;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tog_s1 <= 1'b0;
      r_tog_s2 <= 1'b0;
      r_tog_s3 <= 1'b0;
    end else begin
      r_tog_s1 <= i_toggle;
      r_tog_s2 <= r_tog_s1;
      r_tog_s3 <= r_tog_s2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_win     <= '0;
      r_edges   <= '0;
      r_present <= 1'b0;
    end else if (r_win == c_WIN_LAST) begin
      r_win     <= '0;
      r_edges   <= '0;
      r_present <= (w_edges_inc == c_EDGE_MAX);
    end else begin
      r_win   <= r_win + c_WIN_W'(1);
      r_edges <= w_edges_inc;
    end
  end

  assign o_clk_present = r_present;

endmodule
`default_nettype wire

// File: rtl/hdmi_rx_clk_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_rx_clk_rst_seq
//  Purpose  : HDMI RX serial-clock bring-up sequencer. Waits for pixel-clock
//             activity, pulses the MMCM reset, waits for lock with a timeout
//             and retry, then releases the deserializer reset after a settle
//             interval. Restarts on lock loss or pixel-clock loss.
//  Ports    : i_clk      free-running system clock (only clock)
//             i_rst_n    synchronous active-low reset
//             bus.slave  toggle/lock inputs, MMCM/serdes resets, ready,
//                        debug state, retry counter, timeout pulse
//  Revision : 1.0  initial release
// ============================================================================
module hdmi_rx_clk_rst_seq
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = c_DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = c_DEF_SETTLE_CYCLES,
  parameter int unsigned ACT_WINDOW    = c_DEF_ACT_WINDOW,
  parameter int unsigned MIN_EDGES     = c_DEF_MIN_EDGES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  hdmi_rx_clk_rst_seq_if.slave  bus
);

  localparam int unsigned c_RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned c_TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned c_SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_CYCLES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = '1;

  seq_state_t           r_state;
  seq_state_t           w_next_state;
  logic                 w_state_change;
  logic                 w_timeout;
  logic                 w_clk_present;
  logic                 r_lock_s1;
  logic                 r_lock_s2;
  logic                 w_locked_s;
  logic [c_RST_W-1:0]   r_rst_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic [c_SET_W-1:0]   r_set_cnt;
  logic                 r_mmcm_rst;
  logic                 r_serdes_rst;
  logic                 r_ready;
  logic                 r_timeout;
  logic [c_RETRY_W-1:0] r_retry_cnt;

  hdmi_rx_clk_activity #(
    .ACT_WINDOW (ACT_WINDOW),
    .MIN_EDGES  (MIN_EDGES)
  ) u_activity (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_toggle      (bus.i_pixclk_toggle),
    .o_clk_present (w_clk_present)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= bus.i_mmcm_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  assign w_locked_s = r_lock_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pixel-clock loss overrides everything; inside WAIT_LOCK a lock seen in
  // the same cycle as the timeout wins, so no retry is counted then.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    if ((r_state != ST_IDLE) && !w_clk_present) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_clk_present) w_next_state = ST_MMCM_RST;
        end
        ST_MMCM_RST: begin
          if (r_rst_cnt == c_RST_LAST) w_next_state = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = ST_SETTLE;
          end else if (r_to_cnt == c_TO_LAST) begin
            w_next_state = ST_MMCM_RST;
            w_timeout    = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!w_locked_s) begin
            w_next_state = ST_MMCM_RST;
          end else if (r_set_cnt == c_SET_LAST) begin
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) w_next_state = ST_MMCM_RST;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  assign w_state_change = (w_next_state != r_state);

  // Each counter only runs in its own state and is zero on entry; the FSM
  // leaves the state at the terminal count, so none of them can wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rst_cnt <= '0;
      r_to_cnt  <= '0;
      r_set_cnt <= '0;
    end else begin
      r_rst_cnt <= (w_state_change || (r_state != ST_MMCM_RST)) ?
                   '0 : r_rst_cnt + c_RST_W'(1);
      r_to_cnt  <= (w_state_change || (r_state != ST_WAIT_LOCK)) ?
                   '0 : r_to_cnt + c_TO_W'(1);
      r_set_cnt <= (w_state_change || (r_state != ST_SETTLE)) ?
                   '0 : r_set_cnt + c_SET_W'(1);
    end
  end

  // Outputs are decoded from the next state into flops, so they track the
  // registered state exactly and are glitch-free.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mmcm_rst   <= 1'b1;
      r_serdes_rst <= 1'b1;
      r_ready      <= 1'b0;
      r_timeout    <= 1'b0;
      r_retry_cnt  <= '0;
    end else begin
      r_mmcm_rst   <= (w_next_state == ST_IDLE) || (w_next_state == ST_MMCM_RST);
      r_serdes_rst <= (w_next_state != ST_RUN);
      r_ready      <= (w_next_state == ST_RUN);
      r_timeout    <= w_timeout;
      if (w_timeout && (r_retry_cnt != c_RETRY_MAX)) begin
        r_retry_cnt <= r_retry_cnt + c_RETRY_W'(1);
      end
    end
  end

  assign bus.o_mmcm_rst   = r_mmcm_rst;
  assign bus.o_serdes_rst = r_serdes_rst;
  assign bus.o_ready      = r_ready;
  assign bus.o_state      = r_state;
  assign bus.o_retry_cnt  = r_retry_cnt;
  assign bus.o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: doc/hdmi_rx_clk_rst_seq.md
Name: hdmi_rx_clk_rst_seq

Overview:
Reset/bring-up sequencer for the HDMI RX serial clock MMCM and the downstream TMDS deserializers. It runs on a free-running system clock and qualifies pixel-clock activity from a toggle signal generated in the pixel-clock domain. It drives the MMCM reset, waits for lock with a timeout, then releases the deserializer reset after a settle interval. On lock loss or pixel-clock loss it restarts the sequence.

Parameters:
RST_CYCLES, 16, cycles o_mmcm_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before retry (>=1)
SETTLE_CYCLES, 64, cycles after sync'd lock before o_serdes_rst deasserts (>=1)
ACT_WINDOW, 1024, activity-detection window length in cycles
MIN_EDGES, 4, toggle edges per window required to declare pixel clock present (1..ACT_WINDOW/2)

Ports:
i_clk  in  1  free-running system clock; the only clock
i_rst_n  in  1  synchronous active-low reset
i_pixclk_toggle  in  1  async; toggles once per N pixel clocks (N chosen by the pixel domain)
i_mmcm_locked  in  1  async; MMCM LOCKED
o_mmcm_rst  out  1  MMCM RST
o_serdes_rst  out  1  deserializer/pixel-domain reset, active-high
o_ready  out  1  sequence complete, link clocking valid
o_state  out  3  current FSM state encoding, for debug
o_retry_cnt  out  8  lock-timeout retries since reset, saturating at 255
o_timeout  out  1  one-cycle pulse on each lock timeout

Behaviour:
- Reset is synchronous, active-low, sampled on the i_clk rising edge. While i_rst_n=0: state=IDLE, o_mmcm_rst=1, o_serdes_rst=1, o_ready=0, o_retry_cnt=0, o_timeout=0, all counters and sync flops=0. Reset asserted mid-sequence aborts immediately on the next edge.
- i_pixclk_toggle and i_mmcm_locked each pass through a 2-flop synchronizer. i_pixclk_toggle has a third flop for edge detection. Synchronizer delay: 2 cycles.
- Activity detector: window counter runs 0..ACT_WINDOW-1 and wraps. An edge counter counts sync'd toggle edges and saturates at MIN_EDGES. At wrap, clk_present <= (edges >= MIN_EDGES) and the edge counter clears. clk_present resets to 0.
- States (o_state encoding): IDLE=0, MMCM_RST=1, WAIT_LOCK=2, SETTLE=3, RUN=4.
- IDLE: o_mmcm_rst=1, o_serdes_rst=1. Moves to MMCM_RST when clk_present=1.
- MMCM_RST: o_mmcm_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: o_mmcm_rst=0, timer counts.
  - locked_s=1 -> SETTLE.
  - Timer reaches LOCK_TIMEOUT-1 without lock -> one-cycle o_timeout, o_retry_cnt++ (saturating), -> MMCM_RST.
  - If lock and timeout occur in the same cycle, lock wins.
- SETTLE: o_mmcm_rst=0, o_serdes_rst=1. After SETTLE_CYCLES cycles of continuous locked_s=1 -> RUN. Any drop of locked_s -> MMCM_RST.
- RUN: o_serdes_rst=0, o_ready=1.
  - locked_s=0 -> MMCM_RST.
- Every state except IDLE: clk_present=0 -> IDLE. This takes priority over all other transitions.
- Outputs are registered: they change the cycle after the state change. o_ready=1 iff registered state==RUN. o_serdes_rst=0 only in RUN.
- All counters are sized by $clog2(param+1) and clear on every state entry. No counter wraps except the activity window.

Decomposition:
- Shared package hdmi_rx_pkg: state enum/localparams (IDLE..RUN), 3-bit state width, and default timing constants shared with the other RX blocks.
- One sub-module is natural: hdmi_rx_clk_activity. It contains the toggle synchronizer, edge detector and window counter, and outputs clk_present.
- The lock synchronizer stays inline.

Test Plan:
- Params RST=4, TIMEOUT=50, SETTLE=8, WINDOW=32, MIN_EDGES=4. Toggle every 2 cycles, lock asserted 10 cycles after o_mmcm_rst falls -> o_mmcm_rst high exactly 4 cycles; o_serdes_rst falls 8 cycles after sync'd lock plus 1 register cycle; o_ready=1, o_state=4.
- Toggle active, lock never asserted -> o_timeout pulses every 54 cycles (4 rst + 50 wait), o_retry_cnt increments 1,2,3; after 300 retries o_retry_cnt=255.
- In RUN, drop i_mmcm_locked -> within 3 cycles o_ready=0, o_serdes_rst=1, o_mmcm_rst=1, o_state=1; the sequence re-completes when lock returns.
- Toggle stops in RUN -> at the next window wrap (<=32 cycles plus sync) o_state=0, o_ready=0; toggling resumes -> full sequence restarts.
- Lock glitch low for 1 cycle during SETTLE -> returns to MMCM_RST; o_ready never asserts during the glitch.
- Assert i_rst_n=0 for one cycle mid-WAIT_LOCK -> next cycle all outputs are at reset values and o_retry_cnt=0.
